// File: rtl/weight_loader.sv
// weight_loader: frames a row-major AXI-stream of ROWS*COLS words into a weight matrix; `WEIGHT_LOADER_SHADOW_EN selects double buffering.
// Latency: weights/weights_valid/load_count update the cycle after the final beat; load_error pulses the cycle after the bad beat.
// Backpressure: none applied; TREADY is held high in every state after reset, and bad frames are dropped rather than stalled.
module weight_loader #(
    parameter int ROWS = 3,
    parameter int COLS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       WEIGHT_AXIS_TDATA,
    input  logic                              WEIGHT_AXIS_TLAST,
    input  logic                              WEIGHT_AXIS_TVALID,
    output logic                              WEIGHT_AXIS_TREADY,
    output logic [0:ROWS-1][0:COLS-1][31:0]   weights,
    output logic                              weights_valid,
    output logic                              load_error,
    output logic [15:0]                       load_count
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    if (ROWS * COLS < 2) begin : g_size_check
        $error("weight_loader: ROWS*COLS must be at least 2");
    end

    typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_READY, ST_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept, at_last, have_committed;
    logic          wr_en, commit, frame_err, idx_clr, idx_adv;

    assign accept  = WEIGHT_AXIS_TVALID && WEIGHT_AXIS_TREADY;
    assign at_last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        commit    = 1'b0;
        frame_err = 1'b0;
        idx_clr   = 1'b0;
        idx_adv   = 1'b0;
        case (state)
            ST_EMPTY, ST_READY, ST_LOAD: begin
                if (accept) begin
                    // Row/col are zero outside ST_LOAD, so the first beat always lands at [0][0].
                    wr_en = 1'b1;
                    if (at_last) begin
                        idx_clr = 1'b1;
                        if (WEIGHT_AXIS_TLAST) begin
                            commit    = 1'b1;
                            state_nxt = ST_READY;
                        end else begin
                            frame_err = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end else if (WEIGHT_AXIS_TLAST) begin
                        frame_err = 1'b1;
                        idx_clr   = 1'b1;
                        state_nxt = have_committed ? ST_READY : ST_EMPTY;
                    end else begin
                        idx_adv   = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && WEIGHT_AXIS_TLAST) state_nxt = have_committed ? ST_READY : ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WEIGHT_AXIS_TREADY <= 1'b0;
            row                <= '0;
            col                <= '0;
            load_error         <= 1'b0;
            load_count         <= '0;
        end else begin
            WEIGHT_AXIS_TREADY <= 1'b1;
            load_error         <= frame_err;
            if (commit) load_count <= load_count + 16'd1;
            if (idx_clr) begin
                row <= '0;
                col <= '0;
            end else if (idx_adv) begin
                if (col == CW'(COLS - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

`ifdef WEIGHT_LOADER_SHADOW_EN
    logic [0:ROWS-1][0:COLS-1][31:0] shadow, shadow_nxt;

    assign have_committed = weights_valid;

    // Commit folds the final beat into the copy so weights switch over in one cycle.
    always_comb begin
        shadow_nxt           = shadow;
        shadow_nxt[row][col] = WEIGHT_AXIS_TDATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow        <= '0;
            weights       <= '0;
            weights_valid <= 1'b0;
        end else begin
            if (wr_en) shadow <= shadow_nxt;
            if (commit) begin
                weights       <= shadow_nxt;
                weights_valid <= 1'b1;
            end
        end
    end
`else
    logic start;

    // In-place loading destroys the old matrix, so nothing survives an error.
    assign have_committed = 1'b0;
    assign start          = wr_en && (state != ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            weights       <= '0;
            weights_valid <= 1'b0;
        end else begin
            if (wr_en) weights[row][col] <= WEIGHT_AXIS_TDATA;
            if (start) weights_valid <= 1'b0;
            if (commit) weights_valid <= 1'b1;
        end
    end
`endif

endmodule
